pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and forwarding controller for the in-order pipeline; sits alongside decode and tracks the in-flight destination registers of the stages behind it (EX, MEM, WB, ...).
- Generalises the current fixed "new instruction every cycle, no abort" flow with load-use stalls, branch-redirect flushes and registered forwarding selects.
- Supports configurable pipeline depth and load latency, and includes stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_if.sv | 22 ++
 rtl/pipe_hazard_ctrl_hazard_match.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 68 ++++++
 tb/tb_pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared tracking-entry type and stage/forwarding constants
package pipe_hazard_ctrl_pkg;
  localparam int REG_AW_MAX = 8;
  localparam int EX = 0;
  localparam int MEM = 1;
  localparam int WB = 2;
  localparam logic [2:0] FWD_REGFILE = 3'd0;
  // rd is sized for the widest supported register file and zero-extended on entry
  typedef struct packed {
    logic valid;
    logic [REG_AW_MAX-1:0] rd;
    logic we;
    logic is_load;
  } entry_t;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode-side request and hazard/forwarding response bundle
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
);
  logic id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic id_rs1_used, id_rs2_used, id_rd_we, id_is_load, ex_redirect;
  logic stall_if, stall_id, flush_id, flush_ex;
  logic [2:0] ex_fwd_rs1_sel, ex_fwd_rs2_sel;
  logic [DEPTH-1:0] stage_valid;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, ex_redirect,
    input stall_if, stall_id, flush_id, flush_ex, ex_fwd_rs1_sel, ex_fwd_rs2_sel, stage_valid, stall_cnt, flush_cnt
  );
  modport slave (
    input id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used, id_rd_we, id_is_load, ex_redirect,
    output stall_if, stall_id, flush_id, flush_ex, ex_fwd_rs1_sel, ex_fwd_rs2_sel, stage_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// hazard_match: per-source match vector and youngest-match forwarding select
module hazard_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH = 3
) (
  input  entry_t [DEPTH-1:0] tbl_i,
  input  logic [REG_AW-1:0]  src_i,
  input  logic               used_i,
  output logic [DEPTH-1:0]   hit_o,
  output logic [2:0]         sel_o
);
  // Scan oldest to youngest so the youngest hit is the last one written
  always_comb begin
    hit_o = '0;
    sel_o = FWD_REGFILE;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      hit_o[k] = used_i && tbl_i[k].valid && tbl_i[k].we && (tbl_i[k].rd != '0) && (tbl_i[k].rd == REG_AW_MAX'(src_i));
      if (hit_o[k] && k <= DEPTH - 2) sel_o = 3'(k + 1);
    end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, redirect flush and registered forwarding selects
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH = 3,
  parameter int LOAD_READY = 2,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  entry_t [DEPTH-1:0] tbl_q;
  entry_t entry_d;
  logic [DEPTH-1:0] hit1, hit2, load_mask, valid_vec;
  logic [2:0] sel1, sel2, sel1_d, sel2_d, sel1_q, sel2_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;
  logic load_use, issue, stall_ev;
  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH)) u_rs1 (
    .tbl_i(tbl_q), .src_i(bus.id_rs1), .used_i(bus.id_rs1_used), .hit_o(hit1), .sel_o(sel1)
  );
  hazard_match #(.REG_AW(REG_AW), .DEPTH(DEPTH)) u_rs2 (
    .tbl_i(tbl_q), .src_i(bus.id_rs2), .used_i(bus.id_rs2_used), .hit_o(hit2), .sel_o(sel2)
  );
  // Loads younger than LOAD_READY cannot forward yet
  always_comb begin
    load_mask = '0;
    valid_vec = '0;
    for (int k = 0; k < DEPTH; k++) begin
      load_mask[k] = (k < LOAD_READY - 1) && tbl_q[k].is_load;
      valid_vec[k] = tbl_q[k].valid;
    end
  end
  assign load_use = bus.id_valid & |((hit1 | hit2) & load_mask);
  assign stall_ev = load_use & ~bus.ex_redirect;
  assign issue = bus.id_valid & ~load_use & ~bus.ex_redirect;
  assign entry_d = issue ? entry_t'{valid: 1'b1, rd: REG_AW_MAX'(bus.id_rd), we: bus.id_rd_we, is_load: bus.id_is_load} : '0;
  assign sel1_d = issue ? sel1 : FWD_REGFILE;
  assign sel2_d = issue ? sel2 : FWD_REGFILE;
  assign stall_cnt_d = (stall_ev && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = (bus.ex_redirect && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= '0;
      sel1_q <= FWD_REGFILE;
      sel2_q <= FWD_REGFILE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      tbl_q <= {tbl_q[DEPTH-2:0], entry_d};
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  // Combinational controls are forced low while reset is held
  assign bus.stall_if = rst_n & stall_ev;
  assign bus.stall_id = rst_n & stall_ev;
  assign bus.flush_id = rst_n & bus.ex_redirect;
  assign bus.flush_ex = rst_n & (bus.ex_redirect | load_use);
  assign bus.ex_fwd_rs1_sel = sel1_q;
  assign bus.ex_fwd_rs2_sel = sel2_q;
  assign bus.stage_valid = valid_vec;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios for stalls, flushes, forwarding and counters
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5), .DEPTH(3), .CNT_W(16)) bus ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .DEPTH(3), .CNT_W(4)) bus4 ();
  assign bus4.id_valid = bus.id_valid;
  assign bus4.id_rs1 = bus.id_rs1;
  assign bus4.id_rs2 = bus.id_rs2;
  assign bus4.id_rd = bus.id_rd;
  assign bus4.id_rs1_used = bus.id_rs1_used;
  assign bus4.id_rs2_used = bus.id_rs2_used;
  assign bus4.id_rd_we = bus.id_rd_we;
  assign bus4.id_is_load = bus.id_is_load;
  assign bus4.ex_redirect = bus.ex_redirect;

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_READY(2), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(3), .LOAD_READY(2), .CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we, input logic ld, input logic redir);
    bus.id_valid = v;
    bus.id_rs1 = rs1;
    bus.id_rs1_used = u1;
    bus.id_rs2 = rs2;
    bus.id_rs2_used = u2;
    bus.id_rd = rd;
    bus.id_rd_we = we;
    bus.id_is_load = ld;
    bus.ex_redirect = redir;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 5, 1, 6, 1, 7, 1, 1, 1);
    n_chk++;
    if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl got %b want 0000", {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex});
    end
    step();
    n_chk++;
    if (bus.stage_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid got %b want 000", bus.stage_valid); end
    n_chk++;
    if ({bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel} !== 6'd0) begin
      n_fail++; $display("FAIL reset_sel got %0d/%0d want 0/0", bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel);
    end
    n_chk++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu_fwd();
    drive(1, 1, 1, 2, 1, 5, 1, 0, 0);
    step();
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0);
    n_chk++;
    if (bus.stall_if !== 1'b0 || bus.flush_ex !== 1'b0) begin
      n_fail++; $display("FAIL alu_nostall got %b%b want 00", bus.stall_if, bus.flush_ex);
    end
    step();
    n_chk++;
    if (bus.ex_fwd_rs1_sel !== 3'd1 || bus.ex_fwd_rs2_sel !== 3'd0) begin
      n_fail++; $display("FAIL alu_sel got %0d/%0d want 1/0", bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel);
    end
    n_chk++;
    if (bus.stage_valid !== 3'b011) begin n_fail++; $display("FAIL alu_valid got %b want 011", bus.stage_valid); end
  endtask

  task automatic test_load_use();
    drive(1, 2, 1, 0, 0, 7, 1, 1, 0);
    step();
    drive(1, 7, 1, 7, 1, 8, 1, 0, 0);
    n_chk++;
    if ({bus.stall_if, bus.stall_id, bus.flush_ex, bus.flush_id} !== 4'b1110) begin
      n_fail++; $display("FAIL lu_ctl got %b want 1110", {bus.stall_if, bus.stall_id, bus.flush_ex, bus.flush_id});
    end
    step();
    n_chk++;
    if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt got %0d want 1", bus.stall_cnt); end
    n_chk++;
    if (bus.stage_valid !== 3'b110) begin n_fail++; $display("FAIL lu_bubble got %b want 110", bus.stage_valid); end
    n_chk++;
    if ({bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel} !== 6'd0) begin
      n_fail++; $display("FAIL lu_bubble_sel got %0d/%0d want 0/0", bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel);
    end
    n_chk++;
    if (bus.stall_if !== 1'b0 || bus.flush_ex !== 1'b0) begin
      n_fail++; $display("FAIL lu_release got %b%b want 00", bus.stall_if, bus.flush_ex);
    end
    step();
    n_chk++;
    if (bus.ex_fwd_rs1_sel !== 3'd2 || bus.ex_fwd_rs2_sel !== 3'd2) begin
      n_fail++; $display("FAIL lu_sel got %0d/%0d want 2/2", bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel);
    end
    n_chk++;
    if (bus.stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_hold got %0d want 1", bus.stall_cnt); end
  endtask

  task automatic test_redirect();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0);
    step();
    drive(1, 7, 1, 7, 1, 8, 1, 0, 1);
    n_chk++;
    if ({bus.flush_id, bus.flush_ex, bus.stall_if, bus.stall_id} !== 4'b1100) begin
      n_fail++; $display("FAIL redir_ctl got %b want 1100", {bus.flush_id, bus.flush_ex, bus.stall_if, bus.stall_id});
    end
    step();
    n_chk++;
    if (bus.flush_cnt !== 16'd1 || bus.stall_cnt !== 16'd1) begin
      n_fail++; $display("FAIL redir_cnt got %0d/%0d want 1/1", bus.flush_cnt, bus.stall_cnt);
    end
    n_chk++;
    if (bus.stage_valid[0] !== 1'b0) begin n_fail++; $display("FAIL redir_e0 got %b want 0", bus.stage_valid[0]); end
  endtask

  task automatic test_x0_unused();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
    step();
    drive(1, 0, 1, 0, 1, 1, 1, 0, 0);
    n_chk++;
    if (bus.stall_if !== 1'b0) begin n_fail++; $display("FAIL x0_stall got %b want 0", bus.stall_if); end
    step();
    n_chk++;
    if ({bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel} !== 6'd0) begin
      n_fail++; $display("FAIL x0_sel got %0d/%0d want 0/0", bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel);
    end
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0);
    step();
    drive(1, 10, 1, 9, 0, 11, 1, 0, 0);
    n_chk++;
    if (bus.stall_if !== 1'b0) begin n_fail++; $display("FAIL unused_stall got %b want 0", bus.stall_if); end
    step();
    n_chk++;
    if ({bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel} !== 6'd0) begin
      n_fail++; $display("FAIL unused_sel got %0d/%0d want 0/0", bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel);
    end
  endtask

  task automatic test_youngest_retire();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
      step();
    end
    drive(1, 3, 1, 0, 0, 12, 1, 0, 0);
    step();
    n_chk++;
    if (bus.ex_fwd_rs1_sel !== 3'd1) begin n_fail++; $display("FAIL young_sel got %0d want 1", bus.ex_fwd_rs1_sel); end
    idle();
    step(); step(); step();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
    step();
    idle();
    step(); step();
    n_chk++;
    if (bus.stage_valid !== 3'b100) begin n_fail++; $display("FAIL retire_valid got %b want 100", bus.stage_valid); end
    drive(1, 4, 1, 4, 1, 13, 1, 0, 0);
    step();
    n_chk++;
    if ({bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel} !== 6'd0) begin
      n_fail++; $display("FAIL retire_sel got %0d/%0d want 0/0", bus.ex_fwd_rs1_sel, bus.ex_fwd_rs2_sel);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 5, 1, 0, 1);
      step();
    end
    n_chk++;
    if (bus4.flush_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_cnt4 got %0d want 15", bus4.flush_cnt); end
    n_chk++;
    if (bus.flush_cnt !== 16'd21) begin n_fail++; $display("FAIL sat_cnt16 got %0d want 21", bus.flush_cnt); end
    n_chk++;
    if (bus.stage_valid !== 3'b000) begin n_fail++; $display("FAIL sat_valid got %b want 000", bus.stage_valid); end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 0);
    step();
    drive(1, 5, 1, 0, 0, 6, 1, 0, 1);
    @(negedge clk);
    n_chk++;
    if (bus.stage_valid[0] !== 1'b1 || bus.flush_id !== 1'b1) begin
      n_fail++; $display("FAIL ares_pre got %b%b want 11", bus.stage_valid[0], bus.flush_id);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex} !== 4'b0000) begin
      n_fail++; $display("FAIL ares_ctl got %b want 0000", {bus.stall_if, bus.stall_id, bus.flush_id, bus.flush_ex});
    end
    n_chk++;
    if (bus.stage_valid !== 3'b000 || bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
      n_fail++; $display("FAIL ares_state got %b %0d %0d want 000 0 0", bus.stage_valid, bus.stall_cnt, bus.flush_cnt);
    end
    n_chk++;
    if (bus4.flush_cnt !== 4'd0) begin n_fail++; $display("FAIL ares_cnt4 got %0d want 0", bus4.flush_cnt); end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_redirect();
    test_x0_unused();
    test_youngest_retire();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
